// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared fetch-unit types: FSM state encoding, NOP word, default reset pc
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - fetch-unit bus bundle: imem request/response, decode handoff, redirect
interface ifu_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_valid, inst, inst_pc, fetch_fault,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_valid, inst, inst_pc, fetch_fault,
    output inst_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu.sv
// rtl/ifu.sv - single-outstanding instruction fetch unit with redirect handling
// Optional IFU_MISALIGN_CHECK_EN: misaligned redirects fault instead of being aligned down.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic   clk,
  input  logic   rst_n,
  ifu_if.master  bus
);

  ifu_state_e  state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] inst_q, inst_n;
  logic [31:0] inst_pc_q, inst_pc_n;
  logic        fault_q, fault_n;
  logic        handshake;
  logic        misalign;
  logic [31:0] redir_pc;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = (bus.redirect_pc[1:0] != 2'b00);
  assign redir_pc = bus.redirect_pc;
`else
  assign misalign = 1'b0;
  assign redir_pc = bus.redirect_pc & ~32'h3;
`endif

  // Request is gated by rst_n so nothing is issued while reset is held.
  assign bus.imem_req_valid = (state_q == ST_REQ) && rst_n;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == ST_HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_fault    = fault_q;

  assign handshake = bus.imem_req_valid && bus.imem_req_ready;

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    inst_n    = inst_q;
    inst_pc_n = inst_pc_q;
    fault_n   = fault_q;
    if (bus.redirect_valid) begin
      pc_n = redir_pc;
      if (misalign) begin
        state_n   = ST_HOLD;
        inst_n    = NOP_INST;
        inst_pc_n = bus.redirect_pc;
        fault_n   = 1'b1;
      end else begin
        // Any in-flight response belongs to the old path and must be swallowed.
        unique case (state_q)
          ST_REQ:  state_n = handshake ? ST_DROP : ST_REQ;
          ST_WAIT: state_n = bus.imem_resp_valid ? ST_REQ : ST_DROP;
          ST_HOLD: state_n = ST_REQ;
          ST_DROP: state_n = bus.imem_resp_valid ? ST_REQ : ST_DROP;
          default: state_n = ST_REQ;
        endcase
      end
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (handshake) state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_resp_valid) begin
            inst_n    = bus.imem_resp_data;
            inst_pc_n = pc_q;
            fault_n   = bus.imem_resp_err;
            state_n   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            pc_n    = pc_q + 32'd4;
            state_n = ST_REQ;
          end
        end
        ST_DROP: begin
          if (bus.imem_resp_valid) state_n = ST_REQ;
        end
        default: state_n = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      inst_q    <= inst_n;
      inst_pc_q <= inst_pc_n;
      fault_q   <= fault_n;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - randomized + directed bench for ifu against a transaction-level fetch model
module tb_ifu;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifu_if bus ();

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Fetch model: pc, one request in flight (kept or stale), one held instruction.
  logic [31:0] m_pc;
  bit          m_pend, m_want, m_held;
  logic [31:0] m_inst, m_ipc;
  bit          m_fault;

  // Memory responder state and stimulus knobs.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data_q;
  bit          mem_err_q;
  int          lat_sel;
  int          err_mode;
  bit          use_fixed;
  logic [31:0] fixed_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_pend = 0; m_want = 0; m_held = 0;
    m_inst = NOP_INST; m_ipc = 32'h0; m_fault = 0;
    mem_busy = 0; mem_cnt = 0; mem_data_q = 32'h0; mem_err_q = 0;
  endtask

  task automatic drive_idle();
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
  endtask

  // Called at a negedge: check outputs, drive one cycle of inputs, advance model, wait a cycle.
  task automatic step(input bit rdv, input logic [31:0] rpc, input bit req_rdy, input bit i_rdy);
    bit          exp_rv, hs, rv, re, mis;
    logic [31:0] rd;
    #1;
    exp_rv = !m_held && !m_pend;
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", bus.imem_req_addr, m_pc);
    check("inst_valid", 32'(bus.inst_valid), 32'(m_held));
    if (m_held) begin
      check("inst", bus.inst, m_inst);
      check("inst_pc", bus.inst_pc, m_ipc);
      check("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
    end

    rv = mem_busy && (mem_cnt == 0);
    rd = mem_data_q;
    re = mem_err_q;
    bus.redirect_valid  = rdv;
    bus.redirect_pc     = rpc;
    bus.imem_req_ready  = req_rdy;
    bus.inst_ready      = i_rdy;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rv ? rd : $urandom;
    bus.imem_resp_err   = rv ? re : 1'($urandom);

    hs = exp_rv && req_rdy;
    if (rv) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy   = 1;
      mem_cnt    = (lat_sel < 0) ? int'($urandom_range(0, 3)) : lat_sel;
      mem_data_q = use_fixed ? fixed_data : mem_word(m_pc);
      mem_err_q  = (err_mode == 1) || (err_mode == 2 && $urandom_range(0, 7) == 0);
    end

    mis = 0;
`ifdef IFU_MISALIGN_CHECK_EN
    mis = rdv && (rpc[1:0] != 2'b00);
`endif
    if (mis) begin
      m_pc = rpc; m_held = 1; m_inst = NOP_INST; m_ipc = rpc; m_fault = 1;
    end else if (rdv) begin
      m_pc = {rpc[31:2], 2'b00};
      m_held = 0;
      if (m_pend) begin
        if (rv) m_pend = 0;
        else m_want = 0;
      end else if (hs) begin
        m_pend = 1; m_want = 0;
      end
    end else if (hs) begin
      m_pend = 1; m_want = 1;
    end else if (m_pend && rv) begin
      m_pend = 0;
      if (m_want) begin
        m_held = 1; m_inst = rd; m_ipc = m_pc; m_fault = re;
      end
    end else if (m_held && i_rdy) begin
      m_held = 0;
      m_pc   = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic rnd_step();
    logic [31:0] rpc;
    rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
`ifdef IFU_MISALIGN_CHECK_EN
    rpc[1:0] = 2'b00;
`endif
    step($urandom_range(0, 9) == 0, rpc, $urandom_range(0, 3) != 0, 1'($urandom));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst", bus.inst, 32'h0000_0013);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_fault", 32'(bus.fetch_fault), 32'h0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    lat_sel = 0; err_mode = 0; use_fixed = 0; fixed_data = 32'h0;
    model_reset();
    apply_reset();

    // Zero-wait fetch: REQ, WAIT, HOLD.
    use_fixed = 1; fixed_data = 32'h0000_0093;
    check("t030_addr", bus.imem_req_addr, 32'h8000_0000);
    step(0, 32'h0, 1, 0);
    check("t030_wait_iv", 32'(bus.inst_valid), 32'h0);
    step(0, 32'h0, 1, 0);
    check("t030_iv", 32'(bus.inst_valid), 32'h1);
    check("t030_inst", bus.inst, 32'h0000_0093);
    check("t030_inst_pc", bus.inst_pc, 32'h8000_0000);
    step(0, 32'h0, 1, 1);
    check("t030_next_addr", bus.imem_req_addr, 32'h8000_0004);
    use_fixed = 0;

    // Decode stall in HOLD.
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0, 1, 0);
      check("t031_inst", bus.inst, mem_word(32'h8000_0004));
      check("t031_no_req", 32'(bus.imem_req_valid), 32'h0);
    end
    step(0, 32'h0, 1, 1);
    check("t031_next_addr", bus.imem_req_addr, 32'h8000_0008);

    // Redirect while waiting; stale response arrives two cycles later.
    lat_sel = 2;
    step(0, 32'h0, 1, 0);
    step(1, 32'h8000_0100, 1, 0);
    check("t032_drop_iv", 32'(bus.inst_valid), 32'h0);
    step(0, 32'h0, 1, 0);
    check("t032_drop_iv2", 32'(bus.inst_valid), 32'h0);
    step(0, 32'h0, 1, 0);
    check("t032_addr", bus.imem_req_addr, 32'h8000_0100);
    lat_sel = 0;

    // Redirect and accept in the same HOLD cycle.
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    step(1, 32'h8000_0200, 1, 1);
    check("t033_addr", bus.imem_req_addr, 32'h8000_0200);

    // Error response, then clean next fetch.
    err_mode = 1;
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    check("t034_fault", 32'(bus.fetch_fault), 32'h1);
    err_mode = 0;
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    check("t034_fault_clr", 32'(bus.fetch_fault), 32'h0);
    check("t034_inst_pc", bus.inst_pc, 32'h8000_0204);

    // Misaligned redirect from HOLD.
`ifdef IFU_MISALIGN_CHECK_EN
    step(1, 32'h8000_0102, 1, 0);
    check("t035_no_req", 32'(bus.imem_req_valid), 32'h0);
    check("t035_fault", 32'(bus.fetch_fault), 32'h1);
    check("t035_inst_pc", bus.inst_pc, 32'h8000_0102);
    check("t035_inst", bus.inst, 32'h0000_0013);
    step(1, 32'h8000_0300, 1, 0);
    check("t035_realign", bus.imem_req_addr, 32'h8000_0300);
`else
    step(1, 32'h8000_0102, 1, 0);
    check("t035_addr", bus.imem_req_addr, 32'h8000_0100);
`endif

    // pc wraps at the top of the address space.
    step(1, 32'hFFFF_FFFC, 0, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 1);
    check("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

    lat_sel = -1; err_mode = 2;
    for (int i = 0; i < 3000; i++) rnd_step();

    // Reset dropped mid-transaction must abandon the in-flight request.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) rnd_step();
      apply_reset();
      for (int k = 0; k < 40; k++) rnd_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
